load_rd_scheduler: RTL and testbench
====================================

// Module: load_rd_scheduler
// PURPOSE
//  Shares the single AXI read channel between NREQ load-buffer requesters (input/weight/output SRAM loaders).
//  - Round-robin arbitration onto the AR channel; one outstanding burst per requester.
//  - Routes R beats back by rid; counts beats and checks rlast; reports completion/errors per requester.
// PARAMETERS
//  NREQ     3      number of requesters (2..4)
//  ID_BASE  8'h10  arid = ID_BASE + requester index
//  ADDR_W   12     DRAM address width
// PORTS
//  clk         in   1          clock
//  rst_n       in   1          asynchronous active-low reset
//  req_vld     in   NREQ       request valid per requester
//  req_rdy     out  NREQ       request accepted (one-hot or zero)
//  req_addr    in   NREQ*12    DRAM start address, requester i at [12i+11:12i]
//  req_len     in   NREQ*8     burst length-1 (AXI arlen)
//  req_size    in   NREQ*3     beat size (AXI arsize)
//  axi_arid    out  8          AR id
//  axi_araddr  out  12         AR address
//  axi_arlen   out  8          AR length
//  axi_arsize  out  3          AR size
//  axi_arburst out  2          fixed 2'b01 (INCR)
//  axi_arvld   out  1          AR valid
//  axi_arrdy   in   1          AR ready
//  axi_rid     in   8          R id
//  axi_rdata   in   32         R data
//  axi_rresp   in   2          R response (0 = OKAY)
//  axi_rlast   in   1          R last
//  axi_rvld    in   1          R valid
//  axi_rrdy    out  1          R ready (constant 1 out of reset)
//  rsp_vld     out  NREQ       beat for requester i (one-hot)
//  rsp_data    out  32         beat data
//  rsp_last    out  1          final beat of burst
//  rsp_err     out  1          beat carries error (rresp!=0 or rlast/count mismatch)
//  rsp_retry   out  NREQ       burst being re-issued; requester rewinds its SRAM pointer
//  err_unexp   out  1          sticky: beat with unknown/idle rid dropped
// BEHAVIOUR
//  Reset: all outputs 0 except axi_arburst=2'b01; busy[], beat counters, RR pointer (=0), FSM -> AR_IDLE.
//  Reset mid-burst discards all state; arvld drops asynchronously.
//  AR FSM:
//   - AR_IDLE: winner = first i from rr_ptr (wrapping) with req_vld[i] & !busy[i].
//     req_rdy[winner]=1 (combinational); latch fields; busy[winner]<=1; rr_ptr<=winner+1 mod NREQ.
//     Next state AR_SEND.
//   - AR_SEND: arvld=1, fields stable, req_rdy=0 until arvld&arrdy; then AR_IDLE.
//     Next grant possible the cycle after the handshake.
//   - Latency: req accepted in cycle N -> arvld in N+1.
//  R path:
//   - idx = rid-ID_BASE. Beat with idx>=NREQ or !busy[idx] is dropped and sets err_unexp (cleared only by reset).
//   - Valid beat: registered 1 cycle -> rsp_vld[idx], rsp_data, rsp_last=rlast.
//   - Beat counter cnt[idx] (8b) increments per beat.
//   - rsp_err=1 if rresp!=0, or rlast with cnt!=len, or cnt==len without rlast.
//   - In the last case, busy stays set until rlast arrives.
//   - rlast beat clears busy[idx] and cnt[idx] at the clock edge.
//  Simultaneous events:
//   - R rlast for i in the same cycle as req_vld[i]: busy[i] still 1, so no grant to i that cycle.
//   - R beats and AR handshake in the same cycle are independent.
//  Beats of different requesters may interleave arbitrarily.
// CONFIGURATION
//  LD_SCHED_RETRY_EN defined:
//   - Per-requester saved addr/len/size, retry flag, and sticky error flag for the current burst.
//   - On rlast with the sticky error set and retry==0: busy kept; rsp_retry[i] pulses 1 cycle; rsp_err suppressed for that burst.
//   - The re-issue request takes priority over new requests in AR_IDLE; retry<=1.
//   - A second failure reports rsp_err normally and clears busy.
//  LD_SCHED_RETRY_EN undefined: rsp_retry tied 0; errors reported immediately; no saved-request registers.
// TESTING
//  1. req0 addr 0x100 len 3 size 2, arrdy=1 -> arvld next cycle, arid 0x10, araddr 0x100; 4 beats rid 0x10 -> rsp_vld[0] x4, rsp_last on 4th, busy[0] clears.
//  2. req_vld=3'b111 same cycle, arrdy=1 -> grants 0,1,2 (arid 0x10,0x11,0x12, 2 cycles apart); rr_ptr back to 0.
//  3. arrdy low 5 cycles -> arvld and AR fields stable; req_rdy=0 for all requesters throughout.
//  4. Interleaved beats rid 0x11/0x10 alternating, len 1 each -> rsp_vld one-hot matches rid; both rsp_last correct.
//  5. len 3 but rlast on beat 2 -> rsp_err=1 with rsp_last; beat rid 0x7F -> dropped, err_unexp=1.
//  6. rresp=2 on beat 1 of len 3: with macro -> rsp_retry pulse, AR re-issued at the same addr, clean retry without rsp_err; without macro -> rsp_err on beat 1, busy clears at rlast.

Source files
------------

// File: rtl/load_rd_scheduler_if.sv
// AXI read-address / read-data channel bundle for load_rd_scheduler.
// master = scheduler side, slave = memory side.
interface load_rd_scheduler_if #(
   parameter int ADDR_W = 12
);
   logic [7:0]        axi_arid;
   logic [ADDR_W-1:0] axi_araddr;
   logic [7:0]        axi_arlen;
   logic [2:0]        axi_arsize;
   logic [1:0]        axi_arburst;
   logic              axi_arvld;
   logic              axi_arrdy;
   logic [7:0]        axi_rid;
   logic [31:0]       axi_rdata;
   logic [1:0]        axi_rresp;
   logic              axi_rlast;
   logic              axi_rvld;
   logic              axi_rrdy;

   modport master (
      output axi_arid, axi_araddr, axi_arlen, axi_arsize,
      output axi_arburst, axi_arvld,
      input  axi_arrdy,
      input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvld,
      output axi_rrdy
   );

   modport slave (
      input  axi_arid, axi_araddr, axi_arlen, axi_arsize,
      input  axi_arburst, axi_arvld,
      output axi_arrdy,
      output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvld,
      input  axi_rrdy
   );
endinterface

// File: rtl/load_rd_scheduler.sv
// Round-robin AXI read scheduler for NREQ load-buffer requesters.
// Optional burst re-issue on error: define LD_SCHED_RETRY_EN.
module load_rd_scheduler #(
   parameter int         NREQ    = 3,
   parameter logic [7:0] ID_BASE = 8'h10,
   parameter int         ADDR_W  = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_vld,
   output logic [NREQ-1:0]        req_rdy,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*8-1:0]      req_len,
   input  logic [NREQ*3-1:0]      req_size,
   load_rd_scheduler_if.master    axi,
   output logic [NREQ-1:0]        rsp_vld,
   output logic [31:0]            rsp_data,
   output logic                   rsp_last,
   output logic                   rsp_err,
   output logic [NREQ-1:0]        rsp_retry,
   output logic                   err_unexp
);

   localparam int IW = (NREQ > 2) ? 2 : 1;

   typedef enum logic {
      AR_IDLE,
      AR_SEND
   } ar_state_t;

   ar_state_t     state;
   logic [IW-1:0] rr_ptr;
   logic [NREQ-1:0] busy;
   logic [7:0]    cnt   [NREQ];
   logic [7:0]    len_q [NREQ];

   logic          found;
   logic [IW-1:0] win;
   logic          new_go;

   logic [7:0]    ridx;
   logic [IW-1:0] ri;
   logic          rhs;
   logic          rhit;
   logic          rdrop;
   logic          berr;

`ifdef LD_SCHED_RETRY_EN
   logic [ADDR_W-1:0] sv_addr [NREQ];
   logic [2:0]        sv_size [NREQ];
   logic [NREQ-1:0]   rtry;
   logic [NREQ-1:0]   serr;
   logic [NREQ-1:0]   rpend;
   logic              rfound;
   logic [IW-1:0]     rwin;
   logic              rt_go;
`endif

   assign axi.axi_arburst = 2'b01;

   // round-robin search from rr_ptr over idle requesters
   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req_vld[j] && !busy[j]) begin
            found = 1'b1;
            win   = IW'(j);
         end
      end
   end

`ifdef LD_SCHED_RETRY_EN
   // pending re-issues, lowest index first
   always_comb begin
      rfound = 1'b0;
      rwin   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!rfound && rpend[k]) begin
            rfound = 1'b1;
            rwin   = IW'(k);
         end
      end
   end

   assign rt_go  = (state == AR_IDLE) && rfound;
   assign new_go = (state == AR_IDLE) && !rfound && found;
`else
   assign new_go = (state == AR_IDLE) && found;
`endif

   // combinational grant strobe for the winning requester
   always_comb begin
      req_rdy = '0;
      if (new_go) req_rdy[win] = 1'b1;
   end

   // R-channel decode of the incoming beat
   assign ridx  = axi.axi_rid - ID_BASE;
   assign ri    = ridx[IW-1:0];
   assign rhs   = axi.axi_rvld && axi.axi_rrdy;
   assign rhit  = rhs && (ridx < 8'(NREQ)) && busy[ri];
   assign rdrop = rhs && !rhit;
   assign berr  = (axi.axi_rresp != 2'b00)
                || (axi.axi_rlast && (cnt[ri] != len_q[ri]))
                || (!axi.axi_rlast && (cnt[ri] == len_q[ri]));

   // AR channel FSM with registered AR outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= AR_IDLE;
         rr_ptr         <= '0;
         axi.axi_arvld  <= 1'b0;
         axi.axi_arid   <= '0;
         axi.axi_araddr <= '0;
         axi.axi_arlen  <= '0;
         axi.axi_arsize <= '0;
      end else begin
         unique case (state)
            AR_IDLE: begin
`ifdef LD_SCHED_RETRY_EN
               if (rt_go) begin
                  axi.axi_arvld  <= 1'b1;
                  axi.axi_arid   <= ID_BASE + 8'(rwin);
                  axi.axi_araddr <= sv_addr[rwin];
                  axi.axi_arlen  <= len_q[rwin];
                  axi.axi_arsize <= sv_size[rwin];
                  state          <= AR_SEND;
               end else
`endif
               if (new_go) begin
                  axi.axi_arvld  <= 1'b1;
                  axi.axi_arid   <= ID_BASE + 8'(win);
                  axi.axi_araddr <= req_addr[win*ADDR_W +: ADDR_W];
                  axi.axi_arlen  <= req_len[win*8 +: 8];
                  axi.axi_arsize <= req_size[win*3 +: 3];
                  rr_ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
                  state  <= AR_SEND;
               end
            end
            AR_SEND: begin
               if (axi.axi_arrdy) begin
                  axi.axi_arvld <= 1'b0;
                  state         <= AR_IDLE;
               end
            end
            default: state <= AR_IDLE;
         endcase
      end
   end

   // per-requester burst tracking and registered response path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy         <= '0;
         rsp_vld      <= '0;
         rsp_data     <= '0;
         rsp_last     <= 1'b0;
         rsp_err      <= 1'b0;
         err_unexp    <= 1'b0;
         axi.axi_rrdy <= 1'b0;
         for (int k = 0; k < NREQ; k++) begin
            cnt[k]   <= '0;
            len_q[k] <= '0;
         end
`ifdef LD_SCHED_RETRY_EN
         rsp_retry <= '0;
         rtry      <= '0;
         serr      <= '0;
         rpend     <= '0;
         for (int k = 0; k < NREQ; k++) begin
            sv_addr[k] <= '0;
            sv_size[k] <= '0;
         end
`endif
      end else begin
         axi.axi_rrdy <= 1'b1;
         rsp_vld      <= '0;
         rsp_last     <= 1'b0;
         rsp_err      <= 1'b0;
`ifdef LD_SCHED_RETRY_EN
         rsp_retry    <= '0;
`endif
         if (new_go) begin
            busy[win]  <= 1'b1;
            cnt[win]   <= '0;
            len_q[win] <= req_len[win*8 +: 8];
`ifdef LD_SCHED_RETRY_EN
            sv_addr[win] <= req_addr[win*ADDR_W +: ADDR_W];
            sv_size[win] <= req_size[win*3 +: 3];
            rtry[win]    <= 1'b0;
            serr[win]    <= 1'b0;
`endif
         end
`ifdef LD_SCHED_RETRY_EN
         if (rt_go) begin
            rpend[rwin] <= 1'b0;
            rtry[rwin]  <= 1'b1;
         end
`endif
         if (rhit) begin
            rsp_vld[ri] <= 1'b1;
            rsp_data    <= axi.axi_rdata;
            rsp_last    <= axi.axi_rlast;
            cnt[ri]     <= cnt[ri] + 8'd1;
`ifdef LD_SCHED_RETRY_EN
            rsp_err <= berr && rtry[ri];
            if (axi.axi_rlast) begin
               cnt[ri]  <= '0;
               serr[ri] <= 1'b0;
               if ((serr[ri] || berr) && !rtry[ri]) begin
                  rsp_retry[ri] <= 1'b1;
                  rpend[ri]     <= 1'b1;
               end else begin
                  busy[ri] <= 1'b0;
                  rtry[ri] <= 1'b0;
               end
            end else begin
               serr[ri] <= serr[ri] || berr;
            end
`else
            rsp_err <= berr;
            if (axi.axi_rlast) begin
               busy[ri] <= 1'b0;
               cnt[ri]  <= '0;
            end
`endif
         end
         if (rdrop) err_unexp <= 1'b1;
      end
   end

`ifndef LD_SCHED_RETRY_EN
   assign rsp_retry = '0;
`endif

endmodule

// File: tb/tb_load_rd_scheduler.sv
// Directed testbench for load_rd_scheduler.
// Expected values are hand-computed per scenario.
module tb_load_rd_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req_vld;
   logic [2:0]  req_rdy;
   logic [35:0] req_addr;
   logic [23:0] req_len;
   logic [8:0]  req_size;
   logic [2:0]  rsp_vld;
   logic [31:0] rsp_data;
   logic        rsp_last;
   logic        rsp_err;
   logic [2:0]  rsp_retry;
   logic        err_unexp;

   int total = 0;
   int bad = 0;

   load_rd_scheduler_if #(.ADDR_W(12)) axi ();

   load_rd_scheduler #(
      .NREQ(3),
      .ID_BASE(8'h10),
      .ADDR_W(12)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_vld(req_vld),
      .req_rdy(req_rdy),
      .req_addr(req_addr),
      .req_len(req_len),
      .req_size(req_size),
      .axi(axi),
      .rsp_vld(rsp_vld),
      .rsp_data(rsp_data),
      .rsp_last(rsp_last),
      .rsp_err(rsp_err),
      .rsp_retry(rsp_retry),
      .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [11:0] a,
                          input logic [7:0] l, input logic [2:0] s);
      req_addr[i*12 +: 12] = a;
      req_len[i*8 +: 8]    = l;
      req_size[i*3 +: 3]   = s;
   endtask

   task automatic beat(input logic [7:0] id, input logic [31:0] d,
                       input logic [1:0] rs, input logic l);
      axi.axi_rvld  = 1'b1;
      axi.axi_rid   = id;
      axi.axi_rdata = d;
      axi.axi_rresp = rs;
      axi.axi_rlast = l;
      tick();
      axi.axi_rvld  = 1'b0;
      axi.axi_rlast = 1'b0;
      axi.axi_rresp = 2'b00;
   endtask

   function automatic logic [31:0] arw();
      return {axi.axi_arvld, axi.axi_arid, axi.axi_araddr,
              axi.axi_arlen, axi.axi_arsize};
   endfunction

   function automatic logic [39:0] rsw();
      return {rsp_vld, rsp_last, rsp_err, rsp_retry, rsp_data};
   endfunction

   initial begin
      req_vld = '0;
      req_addr = '0;
      req_len = '0;
      req_size = '0;
      axi.axi_arrdy = 1'b0;
      axi.axi_rvld = 1'b0;
      axi.axi_rid = '0;
      axi.axi_rdata = '0;
      axi.axi_rresp = '0;
      axi.axi_rlast = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset", {axi.axi_arvld, axi.axi_arburst, axi.axi_rrdy,
                    req_rdy, rsp_vld, rsp_retry, err_unexp},
          {1'b0, 2'b01, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0});
      rst_n = 1'b1;
      tick();
      chk("rrdy", axi.axi_rrdy, 1'b1);

      // three simultaneous requests, granted 0,1,2 two cycles apart
      set_req(0, 12'h100, 8'd0, 3'd2);
      set_req(1, 12'h200, 8'd0, 3'd2);
      set_req(2, 12'h300, 8'd0, 3'd2);
      req_vld = 3'b111;
      axi.axi_arrdy = 1'b1;
      #1;
      chk("t2 rdy0", req_rdy, 3'b001);
      tick();
      req_vld = 3'b110;
      #1;
      chk("t2 ar0", arw(), {1'b1, 8'h10, 12'h100, 8'd0, 3'd2});
      chk("t2 hold", req_rdy, 3'b000);
      tick();
      chk("t2 rdy1", {axi.axi_arvld, req_rdy}, {1'b0, 3'b010});
      tick();
      req_vld = 3'b100;
      chk("t2 ar1", arw(), {1'b1, 8'h11, 12'h200, 8'd0, 3'd2});
      tick();
      chk("t2 rdy2", req_rdy, 3'b100);
      tick();
      req_vld = 3'b000;
      chk("t2 ar2", arw(), {1'b1, 8'h12, 12'h300, 8'd0, 3'd2});
      tick();
      chk("t2 arvld0", axi.axi_arvld, 1'b0);
      beat(8'h12, 32'hC0C0_0002, 2'b00, 1'b1);
      chk("t2 r2", rsw(), {3'b100, 1'b1, 1'b0, 3'b000, 32'hC0C0_0002});
      beat(8'h10, 32'hC0C0_0000, 2'b00, 1'b1);
      chk("t2 r0", rsw(), {3'b001, 1'b1, 1'b0, 3'b000, 32'hC0C0_0000});
      beat(8'h11, 32'hC0C0_0001, 2'b00, 1'b1);
      chk("t2 r1", rsw(), {3'b010, 1'b1, 1'b0, 3'b000, 32'hC0C0_0001});

      // single 4-beat burst; rr_ptr must be back at 0
      set_req(0, 12'h100, 8'd3, 3'd2);
      req_vld = 3'b111;
      #1;
      chk("t1 rrptr", req_rdy, 3'b001);
      req_vld = 3'b001;
      tick();
      req_vld = 3'b000;
      chk("t1 ar", arw(), {1'b1, 8'h10, 12'h100, 8'd3, 3'd2});
      tick();
      chk("t1 arvld0", axi.axi_arvld, 1'b0);
      for (int b = 0; b < 4; b++) begin
         beat(8'h10, 32'(32'hA000 + b), 2'b00, b == 3);
         chk("t1 beat", rsw(), {3'b001, b == 3, 1'b0, 3'b000,
                                32'(32'hA000 + b)});
      end
      tick();
      chk("t1 idle", rsp_vld, 3'b000);

      // AR stall: fields stable, no grants while arrdy low
      axi.axi_arrdy = 1'b0;
      set_req(0, 12'h2A4, 8'd1, 3'd2);
      set_req(1, 12'h3C0, 8'd1, 3'd2);
      req_vld = 3'b001;
      #1;
      chk("t3 rdy0", req_rdy, 3'b001);
      tick();
      req_vld = 3'b011;
      #1;
      for (int c = 0; c < 5; c++) begin
         chk("t3 stall", {arw(), req_rdy},
             {1'b1, 8'h10, 12'h2A4, 8'd1, 3'd2, 3'b000});
         tick();
      end
      axi.axi_arrdy = 1'b1;
      tick();
      chk("t3 rel", {axi.axi_arvld, req_rdy}, {1'b0, 3'b010});
      tick();
      req_vld = 3'b000;
      chk("t3 ar1", arw(), {1'b1, 8'h11, 12'h3C0, 8'd1, 3'd2});
      tick();
      chk("t3 arvld0", axi.axi_arvld, 1'b0);

      // interleaved beats of requesters 1 and 0
      beat(8'h11, 32'hB001, 2'b00, 1'b0);
      chk("t4 b1a", rsw(), {3'b010, 1'b0, 1'b0, 3'b000, 32'hB001});
      beat(8'h10, 32'hA001, 2'b00, 1'b0);
      chk("t4 a1a", rsw(), {3'b001, 1'b0, 1'b0, 3'b000, 32'hA001});
      beat(8'h11, 32'hB002, 2'b00, 1'b1);
      chk("t4 b1b", rsw(), {3'b010, 1'b1, 1'b0, 3'b000, 32'hB002});
      beat(8'h10, 32'hA002, 2'b00, 1'b1);
      chk("t4 a1b", rsw(), {3'b001, 1'b1, 1'b0, 3'b000, 32'hA002});

      // early rlast and an unknown rid
      set_req(2, 12'h080, 8'd3, 3'd2);
      req_vld = 3'b100;
      #1;
      chk("t5 rdy2", req_rdy, 3'b100);
      tick();
      req_vld = 3'b000;
      tick();
      chk("t5 arvld0", axi.axi_arvld, 1'b0);
      beat(8'h12, 32'hC000, 2'b00, 1'b0);
      chk("t5 c0", rsw(), {3'b100, 1'b0, 1'b0, 3'b000, 32'hC000});
      beat(8'h12, 32'hC001, 2'b00, 1'b1);
      chk("t5 early", rsw(), {3'b100, 1'b1, 1'b1, 3'b000, 32'hC001});
      chk("t5 unexp0", err_unexp, 1'b0);
      beat(8'h7F, 32'hDEAD, 2'b00, 1'b1);
      chk("t5 drop", {rsp_vld, err_unexp}, {3'b000, 1'b1});
      beat(8'h12, 32'hBEEF, 2'b00, 1'b1);
      chk("t5 idle", {rsp_vld, err_unexp}, {3'b000, 1'b1});

      // error response on beat 0 of a 4-beat burst
      set_req(0, 12'h140, 8'd3, 3'd2);
      req_vld = 3'b001;
      #1;
      chk("t6 rdy0", req_rdy, 3'b001);
      tick();
      req_vld = 3'b000;
      tick();
`ifdef LD_SCHED_RETRY_EN
      beat(8'h10, 32'hD000, 2'b10, 1'b0);
      chk("t6 d0", rsw(), {3'b001, 1'b0, 1'b0, 3'b000, 32'hD000});
      beat(8'h10, 32'hD001, 2'b00, 1'b0);
      chk("t6 d1", rsw(), {3'b001, 1'b0, 1'b0, 3'b000, 32'hD001});
      beat(8'h10, 32'hD002, 2'b00, 1'b0);
      chk("t6 d2", rsw(), {3'b001, 1'b0, 1'b0, 3'b000, 32'hD002});
      beat(8'h10, 32'hD003, 2'b00, 1'b1);
      chk("t6 retry", rsw(), {3'b001, 1'b1, 1'b0, 3'b001, 32'hD003});
      tick();
      chk("t6 reissue", {arw(), rsp_retry},
          {1'b1, 8'h10, 12'h140, 8'd3, 3'd2, 3'b000});
      tick();
      chk("t6 arvld0", axi.axi_arvld, 1'b0);
      for (int b = 0; b < 4; b++) begin
         beat(8'h10, 32'(32'hE000 + b), 2'b00, b == 3);
         chk("t6 clean", rsw(), {3'b001, b == 3, 1'b0, 3'b000,
                                 32'(32'hE000 + b)});
      end
`else
      beat(8'h10, 32'hD000, 2'b10, 1'b0);
      chk("t6 d0", rsw(), {3'b001, 1'b0, 1'b1, 3'b000, 32'hD000});
      beat(8'h10, 32'hD001, 2'b00, 1'b0);
      chk("t6 d1", rsw(), {3'b001, 1'b0, 1'b0, 3'b000, 32'hD001});
      beat(8'h10, 32'hD002, 2'b00, 1'b0);
      chk("t6 d2", rsw(), {3'b001, 1'b0, 1'b0, 3'b000, 32'hD002});
      beat(8'h10, 32'hD003, 2'b00, 1'b1);
      chk("t6 d3", rsw(), {3'b001, 1'b1, 1'b0, 3'b000, 32'hD003});
      tick();
      chk("t6 noar", axi.axi_arvld, 1'b0);
`endif
      req_vld = 3'b001;
      #1;
      chk("t6 free", req_rdy, 3'b001);
      req_vld = 3'b000;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
